hssl_link_handshake: RTL and testbench
======================================

// Module: hssl_link_handshake
// PURPOSE
//  Link-bring-up stage between the user datapath and the HSSL transceiver.
//  Exchanges HSK/ACK comma words with the SpiNNaker peer and asserts
//  handshake_complete_out, which drives the transceiver's handshake_complete_in.
//  Once linked, forwards user tx words to the GT and good rx words to the user.
//  Monitors 8b/10b errors and drops the link when the errors persist.
// PARAMETERS
//  NUM_HSK     16             consecutive matching rx words needed to advance
//  ACK_TIMEOUT 65536          max cycles in SEND_ACK before reverting to SEND_HSK
//  MAX_ERRS    4              consecutive erroneous rx words that drop the link
//  HSK_WORD    32'hC0DE5ABC   handshake word; byte0 is K28.5, charisk 4'b0001
//  ACK_WORD    32'hAC6E5ABC   acknowledge word; byte0 is K28.5, charisk 4'b0001
//  IDLE_WORD   32'h000000BC   idle word; charisk 4'b0001
// PORTS
//  clk_in                  in   1   tx_usrclk2; rx path shares it via clock correction
//  reset_in                in   1   synchronous, active-high
//  tx_reset_done_in        in   1   GT tx reset done
//  rx_reset_done_in        in   1   GT rx reset done
//  rx_data_in              in   32  GT rx data
//  rx_charisk_in           in   4   GT rx K-char flags
//  rx_disperr_in           in   4   GT rx disparity error, per byte
//  rx_encerr_in            in   4   GT rx not-in-table error, per byte
//  tx_data_out             out  32  to GT tx data
//  tx_charisk_out          out  4   to GT tx K-char flags
//  usr_tx_data_in          in   32  user tx word
//  usr_tx_charisk_in       in   4   user tx K flags
//  usr_tx_rdy_out          out  1   user word accepted this cycle
//  usr_rx_data_out         out  32  received user word
//  usr_rx_charisk_out      out  4   received K flags
//  usr_rx_vld_out          out  1   usr_rx_* valid this cycle
//  handshake_complete_out  out  1   link established (state == LINKED)
//  err_cnt_out             out  16  saturating count of bad words seen while LINKED
// BEHAVIOUR
//  Reset: state=RESET_WAIT, tx_data_out=IDLE_WORD, tx_charisk_out=4'b0001.
//   All other outputs and counters reset to 0.
//  Word classes:
//   - bad   = |(rx_disperr_in | rx_encerr_in).
//   - HSK/ACK/IDLE = not bad, rx_data_in == the word's value, and rx_charisk_in == 4'b0001.
//  FSM:
//   - Any state -> RESET_WAIT whenever tx_reset_done_in or rx_reset_done_in is 0.
//     This transition has top priority.
//   - RESET_WAIT: tx IDLE. Go to SEND_HSK when both reset-done inputs are 1.
//   - SEND_HSK: tx HSK. match_cnt counts consecutive HSK-or-ACK words; any
//     other word clears it. When match_cnt reaches NUM_HSK, go to SEND_ACK
//     and clear match_cnt.
//   - SEND_ACK: tx ACK. match_cnt counts consecutive ACK words. An HSK word
//     clears match_cnt and the state stays put. When match_cnt reaches NUM_HSK,
//     go to LINKED. tmo_cnt counts cycles spent in SEND_ACK; at ACK_TIMEOUT-1,
//     go to SEND_HSK.
//   - LINKED: err_run counts consecutive bad words; a good word clears it.
//     Go to SEND_HSK when err_run reaches MAX_ERRS or when a HSK word arrives
//     (peer restarted).
//  On every state change, clear match_cnt, tmo_cnt and err_run.
//  Outputs decoded from the state register:
//   - handshake_complete_out = (state == LINKED).
//   - usr_tx_rdy_out = (state == LINKED).
//  Tx datapath, registered, 1-cycle latency:
//   - LINKED: the next tx_data_out/tx_charisk_out = usr_tx_data_in/usr_tx_charisk_in.
//   - Otherwise: the next tx word is the control word for the current state.
//   - The first cycle after entering LINKED still carries ACK; user data follows.
//  Rx datapath, registered, 1-cycle latency:
//   - usr_rx_vld_out = LINKED & !bad & !(ACK or IDLE word).
//   - usr_rx_data_out/usr_rx_charisk_out are registered rx inputs, updated every cycle.
//  err_cnt_out increments on each bad word in LINKED and saturates at 16'hFFFF.
//   It is cleared only by reset_in.
//  Counter widths: $clog2 of the limit + 1. Counters saturate and never wrap.
// TESTING
//  1. Loopback the tx outputs to the rx inputs, reset-dones=1:
//     -> LINKED after 2*NUM_HSK (+ pipeline) cycles; handshake_complete_out=1.
//  2. Peer sends only HSK: -> stays in SEND_ACK and tx=ACK_WORD;
//     after ACK_TIMEOUT cycles -> SEND_HSK.
//  3. LINKED, inject 3 bad words then 1 good word -> link stays up, err_cnt_out=3.
//     Then inject 4 consecutive bad words -> SEND_HSK, err_cnt_out=7.
//  4. LINKED, usr word 32'h12345678 with charisk 0 -> tx_data_out=32'h12345678
//     next cycle. Received 32'hDEADBEEF -> usr_rx_vld_out=1 and usr_rx_data_out=32'hDEADBEEF.
//  5. Drop rx_reset_done_in mid-SEND_ACK and mid-LINKED -> RESET_WAIT next cycle,
//     tx=IDLE_WORD. reset_in while LINKED -> all outputs return to reset values.
//  6. HSK word received in LINKED -> SEND_HSK; usr_tx_rdy_out=0 the next cycle.

Source files
------------

// File: rtl/hssl_link_handshake.sv
// ---------------------------------------------------------------------------
// hssl_link_handshake
//   Link bring-up between the user datapath and the HSSL transceiver.
//   Exchanges HSK/ACK comma words with the peer. Once both sides agree, it
//   raises handshake_complete_out and passes user words through. Persistent
//   8b/10b errors, or a peer restart, drop the link back to the handshake.
//
// Ports
//   clk_in                  tx_usrclk2; the rx path shares it via clock correction
//   reset_in                synchronous, active-high
//   tx_reset_done_in        GT tx reset done
//   rx_reset_done_in        GT rx reset done
//   rx_data_in [31:0]       GT rx data
//   rx_charisk_in [3:0]     GT rx K-char flags
//   rx_disperr_in [3:0]     GT rx disparity error, per byte
//   rx_encerr_in [3:0]      GT rx not-in-table error, per byte
//   tx_data_out [31:0]      GT tx data (registered)
//   tx_charisk_out [3:0]    GT tx K-char flags (registered)
//   usr_tx_data_in [31:0]   user tx word
//   usr_tx_charisk_in [3:0] user tx K flags
//   usr_tx_rdy_out          user word accepted this cycle
//   usr_rx_data_out [31:0]  received word (registered every cycle)
//   usr_rx_charisk_out [3:0] received K flags
//   usr_rx_vld_out          usr_rx_* carries a user word this cycle
//   handshake_complete_out  link established
//   err_cnt_out [15:0]      saturating count of bad words seen while linked
// ---------------------------------------------------------------------------
module hssl_link_handshake #(
  parameter int unsigned NUM_HSK     = 16,
  parameter int unsigned ACK_TIMEOUT = 65536,
  parameter int unsigned MAX_ERRS    = 4,
  parameter logic [31:0] HSK_WORD    = 32'hC0DE5ABC,
  parameter logic [31:0] ACK_WORD    = 32'hAC6E5ABC,
  parameter logic [31:0] IDLE_WORD   = 32'h000000BC
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        tx_reset_done_in,
  input  logic        rx_reset_done_in,
  input  logic [31:0] rx_data_in,
  input  logic [3:0]  rx_charisk_in,
  input  logic [3:0]  rx_disperr_in,
  input  logic [3:0]  rx_encerr_in,
  output logic [31:0] tx_data_out,
  output logic [3:0]  tx_charisk_out,
  input  logic [31:0] usr_tx_data_in,
  input  logic [3:0]  usr_tx_charisk_in,
  output logic        usr_tx_rdy_out,
  output logic [31:0] usr_rx_data_out,
  output logic [3:0]  usr_rx_charisk_out,
  output logic        usr_rx_vld_out,
  output logic        handshake_complete_out,
  output logic [15:0] err_cnt_out
);

  localparam int unsigned MATCH_W = $clog2(NUM_HSK) + 1;
  localparam int unsigned TMO_W   = $clog2(ACK_TIMEOUT) + 1;
  localparam int unsigned ERR_W   = $clog2(MAX_ERRS) + 1;

  localparam logic [3:0]         CTRL_K     = 4'b0001;
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(NUM_HSK - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [ERR_W-1:0]   ERR_LAST   = ERR_W'(MAX_ERRS - 1);

  typedef enum logic [1:0] {
    ST_RESET_WAIT = 2'd0,
    ST_SEND_HSK   = 2'd1,
    ST_SEND_ACK   = 2'd2,
    ST_LINKED     = 2'd3
  } state_e;

  // Saturating increments: counters hold at all-ones instead of wrapping.
  function automatic logic [MATCH_W-1:0] sat_inc_match(input logic [MATCH_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc_16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e             state_q, state_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [ERR_W-1:0]   err_run_q, err_run_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic [31:0]        tx_data_q, tx_data_d;
  logic [3:0]         tx_charisk_q, tx_charisk_d;
  logic [31:0]        rx_data_q, rx_data_d;
  logic [3:0]         rx_charisk_q, rx_charisk_d;
  logic               rx_vld_q, rx_vld_d;

  // Rx word classification. A control word only counts if it arrived clean.
  logic rx_bad, rx_is_hsk, rx_is_ack, rx_is_idle;

  always_comb begin
    rx_bad     = |(rx_disperr_in | rx_encerr_in);
    rx_is_hsk  = !rx_bad && (rx_data_in == HSK_WORD)  && (rx_charisk_in == CTRL_K);
    rx_is_ack  = !rx_bad && (rx_data_in == ACK_WORD)  && (rx_charisk_in == CTRL_K);
    rx_is_idle = !rx_bad && (rx_data_in == IDLE_WORD) && (rx_charisk_in == CTRL_K);
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_run_d   = err_run_q;

    case (state_q)
      ST_RESET_WAIT: begin
        state_d = ST_SEND_HSK;
      end

      ST_SEND_HSK: begin
        // The peer may already be sending ACK, which also proves it heard us.
        if (rx_is_hsk || rx_is_ack) begin
          if (match_cnt_q == MATCH_LAST) state_d = ST_SEND_ACK;
          else                           match_cnt_d = sat_inc_match(match_cnt_q);
        end else begin
          match_cnt_d = '0;
        end
      end

      ST_SEND_ACK: begin
        if (rx_is_ack) begin
          if (match_cnt_q == MATCH_LAST) state_d = ST_LINKED;
          else                           match_cnt_d = sat_inc_match(match_cnt_q);
        end else begin
          match_cnt_d = '0;
        end
        // Completing the link wins over a coincident timeout.
        if (state_d == ST_SEND_ACK) begin
          if (tmo_cnt_q == TMO_LAST) state_d = ST_SEND_HSK;
          else                       tmo_cnt_d = sat_inc_tmo(tmo_cnt_q);
        end
      end

      ST_LINKED: begin
        if (rx_bad) begin
          if (err_run_q == ERR_LAST) state_d = ST_SEND_HSK;
          else                       err_run_d = sat_inc_err(err_run_q);
        end else begin
          err_run_d = '0;
        end
        // A fresh HSK means the peer restarted its bring-up.
        if (rx_is_hsk) state_d = ST_SEND_HSK;
      end

      default: begin
        state_d = ST_RESET_WAIT;
      end
    endcase

    if (!(tx_reset_done_in && rx_reset_done_in)) state_d = ST_RESET_WAIT;

    if (state_d != state_q) begin
      match_cnt_d = '0;
      tmo_cnt_d   = '0;
      err_run_d   = '0;
    end
  end

  // Datapath next values, all decoded from the current state register
  always_comb begin
    case (state_q)
      ST_LINKED: begin
        tx_data_d    = usr_tx_data_in;
        tx_charisk_d = usr_tx_charisk_in;
      end
      ST_SEND_HSK: begin
        tx_data_d    = HSK_WORD;
        tx_charisk_d = CTRL_K;
      end
      ST_SEND_ACK: begin
        tx_data_d    = ACK_WORD;
        tx_charisk_d = CTRL_K;
      end
      default: begin
        tx_data_d    = IDLE_WORD;
        tx_charisk_d = CTRL_K;
      end
    endcase

    rx_data_d    = rx_data_in;
    rx_charisk_d = rx_charisk_in;
    rx_vld_d     = (state_q == ST_LINKED) && !rx_bad && !rx_is_ack && !rx_is_idle;

    err_cnt_d = err_cnt_q;
    if ((state_q == ST_LINKED) && rx_bad) err_cnt_d = sat_inc_16(err_cnt_q);
  end

  // Register stage: control state and the 1-cycle tx/rx datapath
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= ST_RESET_WAIT;
      match_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      err_run_q    <= '0;
      err_cnt_q    <= '0;
      tx_data_q    <= IDLE_WORD;
      tx_charisk_q <= CTRL_K;
      rx_data_q    <= '0;
      rx_charisk_q <= '0;
      rx_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      err_run_q    <= err_run_d;
      err_cnt_q    <= err_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_charisk_q <= tx_charisk_d;
      rx_data_q    <= rx_data_d;
      rx_charisk_q <= rx_charisk_d;
      rx_vld_q     <= rx_vld_d;
    end
  end

  assign tx_data_out            = tx_data_q;
  assign tx_charisk_out         = tx_charisk_q;
  assign usr_rx_data_out        = rx_data_q;
  assign usr_rx_charisk_out     = rx_charisk_q;
  assign usr_rx_vld_out         = rx_vld_q;
  assign err_cnt_out            = err_cnt_q;
  assign handshake_complete_out = (state_q == ST_LINKED);
  assign usr_tx_rdy_out         = (state_q == ST_LINKED);

endmodule

// File: tb/tb_hssl_link_handshake.sv
// ---------------------------------------------------------------------------
// tb_hssl_link_handshake
//   Randomized and directed stimulus for hssl_link_handshake. A behavioural
//   model predicts every cycle's outputs; predictions are queued and a
//   separate monitor compares them against the DUT. Received user words are
//   queued separately and popped whenever the DUT flags usr_rx_vld_out.
//   ACK_TIMEOUT is shortened to keep the timeout scenario brief.
// ---------------------------------------------------------------------------
module tb_hssl_link_handshake;

  localparam int          NUM_HSK     = 16;
  localparam int          ACK_TIMEOUT = 200;
  localparam int          MAX_ERRS    = 4;
  localparam logic [31:0] HSK         = 32'hC0DE5ABC;
  localparam logic [31:0] ACK         = 32'hAC6E5ABC;
  localparam logic [31:0] IDLE        = 32'h000000BC;

  localparam int M_WAIT = 0, M_HSK = 1, M_ACK = 2, M_LINK = 3;

  logic        clk;
  logic        reset_in, tx_reset_done_in, rx_reset_done_in;
  logic [31:0] rx_data_in;
  logic [3:0]  rx_charisk_in, rx_disperr_in, rx_encerr_in;
  logic [31:0] tx_data_out;
  logic [3:0]  tx_charisk_out;
  logic [31:0] usr_tx_data_in;
  logic [3:0]  usr_tx_charisk_in;
  logic        usr_tx_rdy_out;
  logic [31:0] usr_rx_data_out;
  logic [3:0]  usr_rx_charisk_out;
  logic        usr_rx_vld_out;
  logic        handshake_complete_out;
  logic [15:0] err_cnt_out;

  hssl_link_handshake #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_in                 (clk),
    .reset_in               (reset_in),
    .tx_reset_done_in       (tx_reset_done_in),
    .rx_reset_done_in       (rx_reset_done_in),
    .rx_data_in             (rx_data_in),
    .rx_charisk_in          (rx_charisk_in),
    .rx_disperr_in          (rx_disperr_in),
    .rx_encerr_in           (rx_encerr_in),
    .tx_data_out            (tx_data_out),
    .tx_charisk_out         (tx_charisk_out),
    .usr_tx_data_in         (usr_tx_data_in),
    .usr_tx_charisk_in      (usr_tx_charisk_in),
    .usr_tx_rdy_out         (usr_tx_rdy_out),
    .usr_rx_data_out        (usr_rx_data_out),
    .usr_rx_charisk_out     (usr_rx_charisk_out),
    .usr_rx_vld_out         (usr_rx_vld_out),
    .handshake_complete_out (handshake_complete_out),
    .err_cnt_out            (err_cnt_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] tx;
    logic [3:0]  txk;
    logic        linked;
    logic        vld;
    logic [31:0] rxd;
    logic [3:0]  rxk;
    logic [15:0] err;
  } exp_t;

  exp_t        exp_q[$];
  logic [35:0] rxw_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model state
  int          m_st, m_match, m_tmo, m_run, m_err;
  logic [31:0] m_tx, m_rxd;
  logic [3:0]  m_txk, m_rxk;
  logic        m_vld;

  // Values the next drive() applies to the control/user inputs
  logic        g_rst, g_txdone, g_rxdone;
  logic [31:0] g_utx;
  logic [3:0]  g_utxk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of behaviour, derived from the link rules on the inputs just applied.
  task automatic model_step();
    bit   bad, hsk, ack, idle;
    int   ns;
    exp_t e;
    bad  = |(rx_disperr_in | rx_encerr_in);
    hsk  = !bad && rx_data_in == HSK  && rx_charisk_in == 4'b0001;
    ack  = !bad && rx_data_in == ACK  && rx_charisk_in == 4'b0001;
    idle = !bad && rx_data_in == IDLE && rx_charisk_in == 4'b0001;
    if (reset_in) begin
      m_st = M_WAIT; m_match = 0; m_tmo = 0; m_run = 0; m_err = 0;
      m_tx = IDLE; m_txk = 4'b0001; m_vld = 1'b0; m_rxd = '0; m_rxk = '0;
    end else begin
      if (m_st == M_LINK) begin
        m_tx = usr_tx_data_in; m_txk = usr_tx_charisk_in;
      end else begin
        m_tx  = (m_st == M_HSK) ? HSK : (m_st == M_ACK) ? ACK : IDLE;
        m_txk = 4'b0001;
      end
      m_vld = (m_st == M_LINK) && !bad && !ack && !idle;
      m_rxd = rx_data_in;
      m_rxk = rx_charisk_in;
      if (m_st == M_LINK && bad && m_err < 65535) m_err++;
      ns = m_st;
      if (!(tx_reset_done_in && rx_reset_done_in)) ns = M_WAIT;
      else if (m_st == M_WAIT) ns = M_HSK;
      else if (m_st == M_HSK) begin
        m_match = (hsk || ack) ? m_match + 1 : 0;
        if (m_match == NUM_HSK) ns = M_ACK;
      end else if (m_st == M_ACK) begin
        m_match = ack ? m_match + 1 : 0;
        m_tmo   = m_tmo + 1;
        if (m_match == NUM_HSK)      ns = M_LINK;
        else if (m_tmo == ACK_TIMEOUT) ns = M_HSK;
      end else begin
        m_run = bad ? m_run + 1 : 0;
        if (m_run == MAX_ERRS || hsk) ns = M_HSK;
      end
      if (ns != m_st) begin m_match = 0; m_tmo = 0; m_run = 0; end
      m_st = ns;
    end
    e.tx = m_tx; e.txk = m_txk; e.linked = (m_st == M_LINK); e.vld = m_vld;
    e.rxd = m_rxd; e.rxk = m_rxk; e.err = 16'(m_err);
    exp_q.push_back(e);
    if (m_vld) rxw_q.push_back({m_rxk, m_rxd});
  endtask

  // Apply one cycle of stimulus at the falling edge; lb=1 loops predicted tx back to rx.
  task automatic drive(input bit lb, input logic [31:0] d, input logic [3:0] k,
                       input logic [3:0] de, input logic [3:0] ee);
    @(negedge clk);
    reset_in          = g_rst;
    tx_reset_done_in  = g_txdone;
    rx_reset_done_in  = g_rxdone;
    usr_tx_data_in    = g_utx;
    usr_tx_charisk_in = g_utxk;
    if (lb) begin
      rx_data_in = m_tx; rx_charisk_in = m_txk; rx_disperr_in = '0; rx_encerr_in = '0;
    end else begin
      rx_data_in = d; rx_charisk_in = k; rx_disperr_in = de; rx_encerr_in = ee;
    end
    model_step();
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    g_rst = 1'b1; g_txdone = 1'b1; g_rxdone = 1'b1;
    repeat (2) drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
    g_rst = 1'b0;
  endtask

  task automatic link_up(input string name);
    int n;
    n = 0;
    while (m_st != M_LINK && n < 4 * NUM_HSK + 20) begin
      drive(1'b1, 32'h0, 4'h0, 4'h0, 4'h0);
      n++;
    end
    if (m_st != M_LINK) begin
      n_vec++; n_bad++;
      $display("FAIL %s: link not reached within %0d cycles", name, n);
    end else begin
      sample();
      chk({name, "_complete"}, 64'(handshake_complete_out), 64'd1);
      chk({name, "_tx_rdy"}, 64'(usr_tx_rdy_out), 64'd1);
    end
  endtask

  // Monitor: compares every cycle's prediction and every delivered user word.
  initial begin
    exp_t        e;
    logic [35:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 64'(tx_data_out), 64'(e.tx));
        chk("tx_charisk", 64'(tx_charisk_out), 64'(e.txk));
        chk("handshake_complete", 64'(handshake_complete_out), 64'(e.linked));
        chk("usr_tx_rdy", 64'(usr_tx_rdy_out), 64'(e.linked));
        chk("usr_rx_vld", 64'(usr_rx_vld_out), 64'(e.vld));
        chk("usr_rx_data", 64'(usr_rx_data_out), 64'(e.rxd));
        chk("usr_rx_charisk", 64'(usr_rx_charisk_out), 64'(e.rxk));
        chk("err_cnt", 64'(err_cnt_out), 64'(e.err));
      end
      if (usr_rx_vld_out === 1'b1) begin
        if (rxw_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rx_word: got unexpected %h, expected none", usr_rx_data_out);
        end else begin
          w = rxw_q.pop_front();
          chk("rx_word", 64'({usr_rx_charisk_out, usr_rx_data_out}), 64'(w));
        end
      end
    end
  end

  initial begin
    int r;
    reset_in = 1'b1; tx_reset_done_in = 1'b0; rx_reset_done_in = 1'b0;
    rx_data_in = '0; rx_charisk_in = '0; rx_disperr_in = '0; rx_encerr_in = '0;
    usr_tx_data_in = '0; usr_tx_charisk_in = '0;
    g_rst = 1'b1; g_txdone = 1'b0; g_rxdone = 1'b0; g_utx = '0; g_utxk = '0;
    m_st = M_WAIT; m_match = 0; m_tmo = 0; m_run = 0; m_err = 0;
    m_tx = IDLE; m_txk = 4'b0001; m_vld = 1'b0; m_rxd = '0; m_rxk = '0;

    // Reset values
    repeat (3) drive(1'b0, 32'h0, 4'h0, 4'h0, 4'h0);
    sample();
    chk("reset_tx_data", 64'(tx_data_out), 64'(IDLE));
    chk("reset_tx_charisk", 64'(tx_charisk_out), 64'd1);
    chk("reset_complete", 64'(handshake_complete_out), 64'd0);
    chk("reset_err_cnt", 64'(err_cnt_out), 64'd0);

    // Loopback bring-up, then user data both ways
    do_reset();
    link_up("loopback_link");
    g_utx = 32'h12345678; g_utxk = 4'h0;
    drive(1'b0, 32'hDEADBEEF, 4'h0, 4'h0, 4'h0);
    sample();
    chk("usr_tx_passthrough", 64'(tx_data_out), 64'h12345678);
    chk("usr_tx_charisk", 64'(tx_charisk_out), 64'd0);
    chk("usr_rx_vld_deadbeef", 64'(usr_rx_vld_out), 64'd1);
    chk("usr_rx_deadbeef", 64'(usr_rx_data_out), 64'hDEADBEEF);

    // Error runs: 3 bad + 1 good keeps the link, 4 bad drops it
    do_reset();
    link_up("err_link");
    drive(1'b0, $urandom, 4'h0, 4'b0001, 4'h0);
    drive(1'b0, $urandom, 4'h0, 4'h0, 4'b1000);
    drive(1'b0, $urandom, 4'h0, 4'b0110, 4'b0010);
    drive(1'b0, 32'h55AA0001, 4'h0, 4'h0, 4'h0);
    sample();
    chk("err3_link_up", 64'(handshake_complete_out), 64'd1);
    chk("err3_count", 64'(err_cnt_out), 64'd3);
    repeat (4) drive(1'b0, $urandom, 4'h0, 4'b0100, 4'h0);
    sample();
    chk("err7_link_down", 64'(handshake_complete_out), 64'd0);
    chk("err7_count", 64'(err_cnt_out), 64'd7);

    // HSK from the peer while linked restarts the handshake
    do_reset();
    link_up("hsk_link");
    drive(1'b0, HSK, 4'b0001, 4'h0, 4'h0);
    sample();
    chk("peer_hsk_tx_rdy", 64'(usr_tx_rdy_out), 64'd0);

    // Reset-done drop while linked, then reset_in while linked
    do_reset();
    link_up("rstdone_link");
    g_rxdone = 1'b0;
    drive(1'b1, 32'h0, 4'h0, 4'h0, 4'h0);
    sample();
    chk("rxdone_drop_complete", 64'(handshake_complete_out), 64'd0);
    drive(1'b1, 32'h0, 4'h0, 4'h0, 4'h0);
    sample();
    chk("rxdone_drop_tx_idle", 64'(tx_data_out), 64'(IDLE));
    g_rxdone = 1'b1;
    link_up("relink");
    g_rst = 1'b1;
    drive(1'b0, $urandom, 4'h0, 4'b0001, 4'h0);
    sample();
    chk("reset_in_tx", 64'(tx_data_out), 64'(IDLE));
    chk("reset_in_complete", 64'(handshake_complete_out), 64'd0);
    chk("reset_in_vld", 64'(usr_rx_vld_out), 64'd0);
    g_rst = 1'b0;

    // Peer sends only HSK: hold in SEND_ACK until the timeout, then back to HSK
    do_reset();
    repeat (1 + NUM_HSK) drive(1'b0, HSK, 4'b0001, 4'h0, 4'h0);
    repeat (ACK_TIMEOUT - 1) drive(1'b0, HSK, 4'b0001, 4'h0, 4'h0);
    sample();
    chk("hsk_only_tx_ack", 64'(tx_data_out), 64'(ACK));
    drive(1'b0, HSK, 4'b0001, 4'h0, 4'h0);
    sample();
    chk("hsk_only_last_ack", 64'(tx_data_out), 64'(ACK));
    drive(1'b0, HSK, 4'b0001, 4'h0, 4'h0);
    sample();
    chk("hsk_only_timeout_tx_hsk", 64'(tx_data_out), 64'(HSK));

    // Reset-done drop in the middle of SEND_ACK
    repeat (NUM_HSK + 4) drive(1'b0, HSK, 4'b0001, 4'h0, 4'h0);
    g_rxdone = 1'b0;
    repeat (2) drive(1'b0, HSK, 4'b0001, 4'h0, 4'h0);
    sample();
    chk("ack_rxdone_drop_tx_idle", 64'(tx_data_out), 64'(IDLE));
    g_rxdone = 1'b1;

    // Randomized traffic; loopback relinks whenever the model is not linked
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      g_txdone = ($urandom_range(0, 200) != 0);
      g_rxdone = ($urandom_range(0, 200) != 0);
      g_rst    = ($urandom_range(0, 400) == 0);
      g_utx    = $urandom;
      g_utxk   = 4'($urandom_range(0, 15));
      if (m_st != M_LINK) begin
        drive(1'b1, 32'h0, 4'h0, 4'h0, 4'h0);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 2) begin
          repeat ($urandom_range(3, 5))
            drive(1'b0, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), 4'h0);
        end else if (r < 12)
          drive(1'b0, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
        else if (r < 16) drive(1'b0, ACK, 4'b0001, 4'h0, 4'h0);
        else if (r < 20) drive(1'b0, IDLE, 4'b0001, 4'h0, 4'h0);
        else if (r < 22) drive(1'b0, HSK, 4'b0001, 4'h0, 4'h0);
        else if (r < 25) drive(1'b0, ACK, 4'b0011, 4'h0, 4'h0);
        else             drive(1'b0, $urandom, 4'($urandom_range(0, 15)), 4'h0, 4'h0);
      end
    end
    g_rst = 1'b0;

    repeat (3) sample();
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("rx_word_queue_drained", 64'(rxw_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
